// File: rtl/nco_tune_sched.sv
// Retune sequencer for the carrier NCO: jump or linear glide of phase_inc_carr, then settle and flag done.
// Latency: jump lands 2 cycles after transfer; glide steps every RAMP_DIV cycles. Glide path built only with NCO_TUNE_RAMP_EN.
module nco_tune_sched #(
  parameter logic [63:0] INIT_INC   = 64'd0,
  parameter int          RAMP_DIV   = 16,
  parameter int          SETTLE_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_inc,
  input  logic        req_ramp,
  input  logic [63:0] req_step,
  input  logic        abort,
  output logic [63:0] phase_inc_carr,
  output logic        busy,
  output logic        tune_done
);

  typedef enum logic [1:0] {IDLE, JUMP, RAMP, SETTLE} state_t;

  state_t      state, state_nxt;
  logic [63:0] inc_q, inc_nxt;
  logic [63:0] target_q, target_nxt;
  logic [31:0] cnt_q, cnt_nxt;
  logic        done_q, done_nxt;

`ifdef NCO_TUNE_RAMP_EN
  logic [63:0] step_q, step_nxt;
  logic [63:0] diff;
  logic        up;
`else
  // Ramp inputs and divider setting are kept on the interface but have no effect here.
  localparam int unused_ramp_div = RAMP_DIV;
  logic unused_ramp_in;
  assign unused_ramp_in = ^{req_ramp, req_step};
`endif

  assign req_ready      = (state == IDLE) && !reset;
  assign busy           = (state != IDLE);
  assign phase_inc_carr = inc_q;
  assign tune_done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q    <= INIT_INC;
      target_q <= 64'd0;
      cnt_q    <= 32'd0;
      done_q   <= 1'b0;
`ifdef NCO_TUNE_RAMP_EN
      step_q   <= 64'd0;
`endif
    end else begin
      inc_q    <= inc_nxt;
      target_q <= target_nxt;
      cnt_q    <= cnt_nxt;
      done_q   <= done_nxt;
`ifdef NCO_TUNE_RAMP_EN
      step_q   <= step_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    inc_nxt    = inc_q;
    target_nxt = target_q;
    cnt_nxt    = cnt_q;
    done_nxt   = 1'b0;
`ifdef NCO_TUNE_RAMP_EN
    step_nxt   = step_q;
    up         = (target_q > inc_q);
    diff       = up ? (target_q - inc_q) : (inc_q - target_q);
`endif

    case (state)
      IDLE: begin
        if (req_valid) begin
          target_nxt = req_inc;
          state_nxt  = JUMP;
`ifdef NCO_TUNE_RAMP_EN
          step_nxt = req_step;
          if (req_ramp && (req_step != 64'd0) && (req_inc != inc_q)) begin
            state_nxt = RAMP;
            cnt_nxt   = 32'(RAMP_DIV - 1);
          end
`endif
        end
      end
      JUMP: begin
        inc_nxt   = target_q;
        state_nxt = SETTLE;
        cnt_nxt   = 32'(SETTLE_CYC);
      end
`ifdef NCO_TUNE_RAMP_EN
      RAMP: begin
        if (cnt_q == 32'd0) begin
          // Final step clamps onto the target so the glide never overshoots.
          if (diff <= step_q) begin
            inc_nxt   = target_q;
            state_nxt = SETTLE;
            cnt_nxt   = 32'(SETTLE_CYC);
          end else begin
            inc_nxt = up ? (inc_q + step_q) : (inc_q - step_q);
            cnt_nxt = 32'(RAMP_DIV - 1);
          end
        end else begin
          cnt_nxt = cnt_q - 32'd1;
        end
      end
`endif
      SETTLE: begin
        if (cnt_q == 32'd0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort freezes the increment where it stands, even mid-jump.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      inc_nxt   = inc_q;
      cnt_nxt   = 32'd0;
      done_nxt  = 1'b0;
    end
  end

endmodule
